// File: rtl/muldiv_issue_ctrl.sv
// Issue controller for the multi-cycle M-extension ALU: launches one op at a time,
// watches for done with a watchdog, and hands the result to writeback.
module muldiv_issue_ctrl #(
  parameter int TIMEOUT  = 48,
  parameter int TIMER_W  = 6,
  parameter int CACHE_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_alucode,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        alu_start,
  output logic [5:0]  alu_code,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  input  logic [31:0] alu_result,
  input  logic        alu_done,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_err,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, START, WAIT, DRAIN, RESP} state_e;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [5:0]          code_q, code_d;
  logic [31:0]         op1_q, op1_d, op2_q, op2_d;
  logic [4:0]          rd_q, rd_d;
  logic                alu_start_q, alu_start_d;
  logic                wb_valid_q, wb_valid_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic                wb_err_q, wb_err_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                c_valid_q, c_valid_d;
  logic [5:0]          c_code_q, c_code_d;
  logic [31:0]         c_op1_q, c_op1_d, c_op2_q, c_op2_d, c_data_q, c_data_d;

  logic accept;
  logic cache_hit;

  assign req_ready = (state_q == IDLE) && !flush;
  assign busy      = (state_q != IDLE);
  assign accept    = req_valid && req_ready;

  // Exact match on the full request only; a different opcode on the same operands misses.
  assign cache_hit = (CACHE_EN != 0) && c_valid_q && (c_code_q == req_alucode) &&
                     (c_op1_q == req_op1) && (c_op2_q == req_op2);

  assign alu_start = alu_start_q;
  assign alu_code  = code_q;
  assign alu_op1   = op1_q;
  assign alu_op2   = op2_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = rd_q;
  assign wb_data   = wb_data_q;
  assign wb_err    = wb_err_q;

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    rd_d        = rd_q;
    alu_start_d = 1'b0;
    wb_valid_d  = wb_valid_q;
    wb_data_d   = wb_data_q;
    wb_err_d    = wb_err_q;
    timer_d     = timer_q;
    c_valid_d   = c_valid_q;
    c_code_d    = c_code_q;
    c_op1_d     = c_op1_q;
    c_op2_d     = c_op2_q;
    c_data_d    = c_data_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          code_d = req_alucode;
          op1_d  = req_op1;
          op2_d  = req_op2;
          rd_d   = req_rd;
          if (cache_hit) begin
            wb_data_d  = c_data_q;
            wb_err_d   = 1'b0;
            wb_valid_d = 1'b1;
            state_d    = RESP;
          end else begin
            alu_start_d = 1'b1;
            state_d     = START;
          end
        end
      end
      START: begin
        timer_d = '0;
        state_d = flush ? DRAIN : WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (flush) begin
          state_d = alu_done ? IDLE : DRAIN;
        end else if (alu_done) begin
          wb_data_d  = alu_result;
          wb_err_d   = 1'b0;
          wb_valid_d = 1'b1;
          c_valid_d  = 1'b1;
          c_code_d   = code_q;
          c_op1_d    = op1_q;
          c_op2_d    = op2_q;
          c_data_d   = alu_result;
          state_d    = RESP;
        end else if (timer_q == TIMER_LAST) begin
          wb_data_d  = '0;
          wb_err_d   = 1'b1;
          wb_valid_d = 1'b1;
          c_valid_d  = 1'b0;
          state_d    = RESP;
        end
      end
      // The ALU cannot be aborted, so a flushed op is allowed to finish silently.
      DRAIN: begin
        timer_d = timer_q + 1'b1;
        if (alu_done || (timer_q == TIMER_LAST)) begin
          state_d = IDLE;
        end
      end
      RESP: begin
        if (flush || wb_ready) begin
          wb_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      code_q      <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      rd_q        <= '0;
      alu_start_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_err_q    <= 1'b0;
      timer_q     <= '0;
      c_valid_q   <= 1'b0;
      c_code_q    <= '0;
      c_op1_q     <= '0;
      c_op2_q     <= '0;
      c_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      rd_q        <= rd_d;
      alu_start_q <= alu_start_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_err_q    <= wb_err_d;
      timer_q     <= timer_d;
      c_valid_q   <= c_valid_d;
      c_code_q    <= c_code_d;
      c_op1_q     <= c_op1_d;
      c_op2_q     <= c_op2_d;
      c_data_q    <= c_data_d;
    end
  end

endmodule

// File: doc/muldiv_issue_ctrl.md
# muldiv_issue_ctrl

Issue controller for the multi-cycle M-extension ALU. It accepts one MUL/DIV/REM request at a time from the execute stage over a valid/ready handshake. It launches the multi-cycle ALU with a one-cycle start pulse and holds the ALU inputs stable for the whole operation. It then waits for the ALU's `done`, with a timeout watchdog, and presents the result to writeback over a second valid/ready handshake. A single-entry result cache returns repeated identical operations without restarting the ALU.

## Interface
Parameters:
- `TIMEOUT`, 48: maximum cycles spent in WAIT/DRAIN before giving up.
- `TIMER_W`, 6: width of the watchdog counter; must satisfy 2^TIMER_W > TIMEOUT.
- `CACHE_EN`, 1: 1 enables the single-entry result cache; 0 forces every request to miss.

Ports:
- `clk` in 1: single clock, posedge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle when high with `req_valid`.
- `req_alucode` in 6: ALU operation code (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- `req_op1`, `req_op2` in 32: operands.
- `req_rd` in 5: destination register tag.
- `flush` in 1: pipeline flush; kills the in-flight request.
- `alu_start` out 1: start pulse to the multi-cycle ALU; drives its `rst` input.
- `alu_code` out 6: operation code to the ALU.
- `alu_op1`, `alu_op2` out 32: operands to the ALU.
- `alu_result` in 32: ALU result.
- `alu_done` in 1: ALU done flag; the ALU changes it on negedge.
- `wb_valid` out 1: result present for writeback.
- `wb_ready` in 1: writeback accepts.
- `wb_rd` out 5: destination register tag.
- `wb_data` out 32: result data.
- `wb_err` out 1: result produced by timeout; `wb_data`=0.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, START, WAIT, DRAIN, RESP.
- `req_ready` = (state==IDLE) && !`flush`. This is combinational.
- **IDLE, on accept:**
  - Latch code, operands and rd. Drive `alu_code`/`alu_op1`/`alu_op2` from the latched values. Hold them unchanged until the next accept, including through WAIT and DRAIN; the ALU reads the code live every stage.
  - Cache hit (CACHE_EN, cache valid, exact match on code, op1 and op2): load `wb_data` from the cache, go to RESP, leave `alu_start` low.
  - Cache miss: go to START.
- **START:** `alu_start`=1 for exactly this one cycle. Clear the timer. Go to WAIT.
- **WAIT:** increment the timer each cycle. Conditions are evaluated in this priority:
  1. `flush`: go to DRAIN. If `alu_done` is also high that cycle, go straight to IDLE and discard the result.
  2. `alu_done`=1: capture `alu_result` into `wb_data`, set `wb_err`=0, write the cache (code, op1, op2, result, valid=1), go to RESP.
  3. Timer reaches TIMEOUT-1: set `wb_data`=0 and `wb_err`=1, invalidate the cache, go to RESP.
- **DRAIN:** the ALU cannot be aborted, so wait. On `alu_done`, or on timer reaching TIMEOUT-1, go to IDLE. No writeback and no cache update.
- **RESP:** `wb_valid`=1; `wb_rd`/`wb_data`/`wb_err` are held stable.
  - `wb_ready`: transfer, go to IDLE.
  - `flush` (priority over `wb_ready`): go to IDLE, no transfer.
- `flush` in IDLE or START: START still issues its pulse but goes to DRAIN instead of WAIT; in IDLE, `flush` only blocks accept.
- Cache covers exact-match repeats only; MUL followed by MULH on the same operands is a miss.

## Timing
- Reset values (async, immediate on `rst`=0): state=IDLE, `alu_start`=0, `alu_code`=0, `alu_op1`=`alu_op2`=0, `wb_valid`=0, `wb_rd`=0, `wb_data`=0, `wb_err`=0, `busy`=0, cache valid=0, timer=0. After reset, `req_ready`=1 whenever `flush`=0.
- Reset mid-operation drops `alu_start` and abandons the ALU. The ALU is re-armed by the next START.
- All outputs are registered except `req_ready` and `busy` (decoded from state).
- Accept at edge N means `alu_start` is high in cycle N+1.
- `alu_done` is sampled only in WAIT/DRAIN, from the edge ending the START cycle onward. Stale `done` from a previous op is therefore ignored; zero-divide/overflow `done`, raised during start, is caught at that first sample.
- Normal op: `alu_done` rises about 34 cycles after `alu_start` falls. `wb_valid` rises the cycle after `done` is sampled.
- Cache hit: `wb_valid`=1 in cycle N+1 after accept.
- Minimum spacing between accepts: one IDLE cycle after the RESP transfer.

## Test plan
1. MUL 7×6, `wb_ready`=1 → single-cycle `alu_start` the cycle after accept; `alu_code`/`alu_op1`/`alu_op2` stable until `done`; `wb_data`=42, `wb_err`=0, one `wb_valid` cycle.
2. DIV 5/0 (ALU model raises `done` immediately) → `wb_data`=0xFFFFFFFF within 2 cycles of `alu_start` falling. Then hold `wb_ready`=0 for 5 cycles → `wb_valid` and data held.
3. Repeat MUL 7×6 → cache hit: `alu_start` never asserts, `wb_valid`=1 the cycle after accept, `wb_data`=42. Then MULH 7×6 → miss, `alu_start` pulses.
4. `flush` in WAIT cycle 10 → no `wb_valid`; `busy`=1 until `alu_done`; `req_ready`=1 the next cycle. A following DIVU 100/7 returns `wb_data`=14.
5. ALU model never raises `done` → `wb_valid` with `wb_err`=1, `wb_data`=0 at TIMEOUT cycles after START. The same request reissued misses the cache.
6. `rst`=0 mid-WAIT → all outputs at reset values without waiting for `clk`. After release, a MUL 3×(−1) completes with `wb_data`=0xFFFFFFFD.
